// File: rtl/alu_op_sequencer.sv
// Request sequencer for a 3-phase (IDLE/EXEC/WB) ALU: buffers requests in a
// 4-deep FIFO, issues one op at a time in phase with the ALU, and returns results.
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [1:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic [2:0] out_flags,
    output logic [2:0] fifo_level,
    output logic       busy,
    output logic [7:0] done_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_ph;
    logic [9:0]  r_fifoMem [0:3];
    logic [1:0]  r_wrPtr;
    logic [1:0]  r_rdPtr;
    logic [2:0]  r_level;
    logic [2:0]  r_age;
    logic [9:0]  r_operands;
    logic        r_outValid;
    logic [3:0]  r_outResult;
    logic [2:0]  r_outFlags;
    logic [7:0]  r_doneCnt;
    logic        w_push;
    logic        w_issue;
    logic        w_capture;

    assign in_ready   = (r_level < 3'd4);
    assign w_push     = in_valid && in_ready;
    assign fifo_level = r_level;
    assign busy       = (r_state == ST_WAIT);
    assign alu_a      = r_operands[3:0];
    assign alu_b      = r_operands[7:4];
    assign alu_op     = r_operands[9:8];
    assign out_valid  = r_outValid;
    assign out_result = r_outResult;
    assign out_flags  = r_outFlags;
    assign done_cnt   = r_doneCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ph    <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_ph    <= (r_ph == 2'd2) ? 2'd0 : r_ph + 2'd1;
        end
    end

    // Issue only at the end of WB so the op enters the ALU at its next IDLE.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_ph == 2'd2) && (r_level != 3'd0)) begin
                    w_issue     = 1'b1;
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((r_ph == 2'd0) && (r_age >= 3'd4) && (!r_outValid || out_ready)) begin
                    w_capture   = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= {in_op, in_b, in_a};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_level <= 3'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_issue) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_issue})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // r_age counts cycles since issue, saturating once capture becomes legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operands <= 10'd0;
            r_age      <= 3'd0;
        end else if (w_issue) begin
            r_operands <= r_fifoMem[r_rdPtr];
            r_age      <= 3'd1;
        end else if ((r_state == ST_WAIT) && (r_age < 3'd4)) begin
            r_age <= r_age + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_outResult <= 4'd0;
            r_outFlags  <= 3'd0;
            r_doneCnt   <= 8'd0;
        end else if (w_capture) begin
            r_outValid  <= 1'b1;
            r_outResult <= alu_result;
            r_outFlags  <= {alu_overflow, alu_carry, alu_zero};
            r_doneCnt   <= r_doneCnt + 8'd1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a queue-based reference model checked every cycle,
// a 3-phase ALU stand-in, and directed scenarios with hand-computed expectations.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [3:0] inA;
    logic [3:0] inB;
    logic [1:0] inOp;
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [1:0] aluOp;
    logic [3:0] aluResult;
    logic       aluCarry;
    logic       aluZero;
    logic       aluOverflow;
    logic       outValid;
    logic       outReady;
    logic [3:0] outResult;
    logic [2:0] outFlags;
    logic [2:0] fifoLevel;
    logic       busy;
    logic [7:0] doneCnt;

    int testsRun = 0;
    int testsFailed = 0;
    int retCount = 0;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_a        (inA),
        .in_b        (inB),
        .in_op       (inOp),
        .alu_a       (aluA),
        .alu_b       (aluB),
        .alu_op      (aluOp),
        .alu_result  (aluResult),
        .alu_carry   (aluCarry),
        .alu_zero    (aluZero),
        .alu_overflow(aluOverflow),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_result  (outResult),
        .out_flags   (outFlags),
        .fifo_level  (fifoLevel),
        .busy        (busy),
        .done_cnt    (doneCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU arithmetic: returns {overflow, carry, zero, result[3:0]}.
    function automatic logic [6:0] aluRef(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [4:0] wide;
        logic [3:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[3:0];
                c = wide[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'b01: begin
                r = a - b;
                c = (a < b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {v, c, (r == 4'd0), r};
    endfunction

    // Three-phase ALU stand-in: registers its result at the end of EXEC.
    logic [1:0] aluPh;
    always @(posedge clk) begin
        if (rst) begin
            aluPh <= 2'd0;
            {aluOverflow, aluCarry, aluZero, aluResult} <= 7'd0;
        end else begin
            aluPh <= (aluPh == 2'd2) ? 2'd0 : aluPh + 2'd1;
            if (aluPh == 2'd1) begin
                {aluOverflow, aluCarry, aluZero, aluResult} <= aluRef(aluA, aluB, aluOp);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Behavioural model: pending requests as a queue, cycle index since reset,
    // issue/capture decided from the phase and elapsed-cycle rules.
    logic [9:0] mQ[$];
    logic [6:0] retQ[$];
    bit         mActive = 0;
    int         mCycle;
    int         mIssueCycle;
    bit         mBusy;
    logic [3:0] mA;
    logic [3:0] mB;
    logic [1:0] mOp;
    bit         mOutValid;
    logic [3:0] mOutRes;
    logic [2:0] mOutFlags;
    logic [7:0] mDone;
    bit         mPush;
    bit         mIssue;
    bit         mCapture;
    logic [9:0] mHead;
    logic [6:0] mVal;

    always @(posedge clk) begin
        if (rst) begin
            mActive = 1;
            mQ.delete();
            retQ.delete();
            mCycle = 0;
            mIssueCycle = 0;
            mBusy = 0;
            mA = 0;
            mB = 0;
            mOp = 0;
            mOutValid = 0;
            mOutRes = 0;
            mOutFlags = 0;
            mDone = 0;
        end else if (mActive) begin
            mPush    = inValid && (mQ.size() < 4);
            mIssue   = !mBusy && (mCycle % 3 == 2) && (mQ.size() > 0);
            mCapture = mBusy && (mCycle % 3 == 0) && (mCycle - mIssueCycle >= 4)
                       && (!mOutValid || outReady);
            if (mCapture) begin
                mVal = aluRef(mA, mB, mOp);
                mOutRes = mVal[3:0];
                mOutFlags = mVal[6:4];
                mOutValid = 1;
                mDone = mDone + 8'd1;
                mBusy = 0;
            end else if (mOutValid && outReady) begin
                mOutValid = 0;
            end
            if (mIssue) begin
                mHead = mQ.pop_front();
                {mOp, mB, mA} = mHead;
                mBusy = 1;
                mIssueCycle = mCycle;
            end
            if (mPush) begin
                mQ.push_back({inOp, inB, inA});
                retQ.push_back(aluRef(inA, inB, inOp));
            end
            mCycle++;
        end
    end

    // Per-cycle comparison against the model, plus in-order result scoreboard.
    always @(negedge clk) begin
        if (mActive) begin
            checkOutput("in_ready", {31'd0, inReady}, {31'd0, (mQ.size() < 4)});
            checkOutput("fifo_level", {29'd0, fifoLevel}, mQ.size());
            checkOutput("busy", {31'd0, busy}, {31'd0, mBusy});
            checkOutput("alu_operands", {22'd0, aluOp, aluB, aluA}, {22'd0, mOp, mB, mA});
            checkOutput("out_valid", {31'd0, outValid}, {31'd0, mOutValid});
            checkOutput("out_data", {25'd0, outFlags, outResult}, {25'd0, mOutFlags, mOutRes});
            checkOutput("done_cnt", {24'd0, doneCnt}, {24'd0, mDone});
            if (!rst && outValid && outReady) begin
                if (retQ.size() == 0) begin
                    checkOutput("unexpected_result", {25'd0, outFlags, outResult}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("result_order", {25'd0, outFlags, outResult}, {25'd0, retQ.pop_front()});
                    retCount++;
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with rst low).
    task automatic doReset();
        rst = 1'b1;
        inValid = 1'b0;
        outReady = 1'b1;
        inA = 4'd0;
        inB = 4'd0;
        inOp = 2'd0;
        repeat (2) stepCycle();
        rst = 1'b0;
        retCount = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        inValid = 1'b1;
        inA = a;
        inB = b;
        inOp = op;
        stepCycle();
        inValid = 1'b0;
    endtask

    initial begin
        int seen;
        int k;
        rst = 1'b1;
        inValid = 1'b0;
        outReady = 1'b1;
        inA = 4'd0;
        inB = 4'd0;
        inOp = 2'd0;

        // Single op F+1 with reset-state checks
        doReset();
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_fifo_level", {29'd0, fifoLevel}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_done_cnt", {24'd0, doneCnt}, 32'd0);
        applyStimulus(4'hF, 4'h1, 2'b00);
        repeat (2) stepCycle();
        checkOutput("single_busy_c3", {31'd0, busy}, 32'd1);
        checkOutput("single_alu_a_c3", {28'd0, aluA}, 32'hF);
        repeat (3) stepCycle();
        checkOutput("single_valid_c6", {31'd0, outValid}, 32'd0);
        stepCycle();
        checkOutput("single_valid_c7", {31'd0, outValid}, 32'd1);
        checkOutput("single_result_c7", {28'd0, outResult}, 32'h0);
        checkOutput("single_flags_c7", {29'd0, outFlags}, 32'b011);
        checkOutput("single_done_c7", {24'd0, doneCnt}, 32'd1);

        // Overflowing add then borrowing subtract, 6 cycles apart
        doReset();
        applyStimulus(4'h7, 4'h1, 2'b00);
        applyStimulus(4'h3, 4'h5, 2'b01);
        repeat (5) stepCycle();
        checkOutput("ovf_valid_c7", {31'd0, outValid}, 32'd1);
        checkOutput("ovf_result_c7", {28'd0, outResult}, 32'h8);
        checkOutput("ovf_flags_c7", {29'd0, outFlags}, 32'b100);
        repeat (5) stepCycle();
        checkOutput("sub_valid_c12", {31'd0, outValid}, 32'd0);
        stepCycle();
        checkOutput("sub_valid_c13", {31'd0, outValid}, 32'd1);
        checkOutput("sub_result_c13", {28'd0, outResult}, 32'hE);
        checkOutput("sub_flags_c13", {29'd0, outFlags}, 32'b010);
        checkOutput("sub_done_c13", {24'd0, doneCnt}, 32'd2);

        // Six back-to-back pushes under backpressure; the sixth meets a full FIFO
        doReset();
        outReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inValid = 1'b1;
            inA = 4'(i + 1);
            inB = 4'(2 * i);
            inOp = 2'(i);
            if (i == 5) begin
                checkOutput("full_fifo_level", {29'd0, fifoLevel}, 32'd4);
                checkOutput("full_in_ready", {31'd0, inReady}, 32'd0);
            end
            stepCycle();
        end
        inValid = 1'b0;
        repeat (14) stepCycle();
        outReady = 1'b1;
        for (k = 0; k < 200 && !(retQ.size() == 0 && !outValid && fifoLevel == 3'd0 && !busy); k++) begin
            stepCycle();
        end
        checkOutput("full_returned", retCount, 32'd5);

        // Capture deferred while the previous result is held
        doReset();
        outReady = 1'b0;
        applyStimulus(4'hC, 4'hA, 2'b10);
        applyStimulus(4'hC, 4'h3, 2'b11);
        repeat (18) stepCycle();
        checkOutput("bp_busy_c20", {31'd0, busy}, 32'd1);
        checkOutput("bp_valid_c20", {31'd0, outValid}, 32'd1);
        checkOutput("bp_result_c20", {28'd0, outResult}, 32'h8);
        checkOutput("bp_flags_c20", {29'd0, outFlags}, 32'b000);
        stepCycle();
        outReady = 1'b1;
        stepCycle();
        checkOutput("bp_valid_c22", {31'd0, outValid}, 32'd1);
        checkOutput("bp_result_c22", {28'd0, outResult}, 32'hF);
        checkOutput("bp_flags_c22", {29'd0, outFlags}, 32'b000);
        checkOutput("bp_done_c22", {24'd0, doneCnt}, 32'd2);

        // Reset asserted one cycle after issue
        doReset();
        applyStimulus(4'h9, 4'h2, 2'b00);
        applyStimulus(4'h5, 4'h5, 2'b01);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_fifo", {29'd0, fifoLevel}, 32'd0);
        checkOutput("mid_rst_alu", {22'd0, aluOp, aluB, aluA}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, outValid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, inReady}, 32'd1);
        seen = 0;
        repeat (20) begin
            stepCycle();
            if (outValid) seen++;
        end
        checkOutput("mid_rst_stale", seen, 32'd0);

        // 256 completions wrap the counter
        doReset();
        seen = 0;
        for (k = 0; k < 3000 && seen < 256; k++) begin
            inValid = 1'b1;
            inA = 4'($urandom_range(0, 15));
            inB = 4'($urandom_range(0, 15));
            inOp = 2'($urandom_range(0, 3));
            stepCycle();
            if (outValid) begin
                seen++;
                if (seen == 255) checkOutput("wrap_done_255", {24'd0, doneCnt}, 32'd255);
                if (seen == 256) checkOutput("wrap_done_0", {24'd0, doneCnt}, 32'd0);
            end
        end
        inValid = 1'b0;
        checkOutput("wrap_count", seen, 32'd256);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
